// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command sequencer: func codes, flag bit positions,
// branch condition codes and the sequencer state encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SLA = 4'd6;
    localparam logic [3:0] ALU_SRA = 4'd7;
    localparam logic [3:0] ALU_SRL = 4'd8;

    localparam int FLG_C = 2;
    localparam int FLG_S = 1;
    localparam int FLG_Z = 0;

    localparam logic [1:0] COND_BZ  = 2'b00;
    localparam logic [1:0] COND_BNZ = 2'b01;
    localparam logic [1:0] COND_BMI = 2'b10;
    localparam logic [1:0] COND_BPL = 2'b11;

    localparam int ST_W = 2;

    typedef enum logic [ST_W-1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } seq_state_t;

    // Codes above SRL have no ALU operation behind them.
    function automatic logic is_legal_func(input logic [3:0] func);
        return (func <= ALU_SRL);
    endfunction

endpackage

// File: rtl/alu_cond_eval.sv
// Branch condition evaluator: resolves BZ/BNZ/BMI/BPL against the sticky sign/zero flags.
module alu_cond_eval (
    input  logic       i_flag_s,
    input  logic       i_flag_z,
    input  logic [1:0] i_cond,
    output logic       o_taken
);
    import alu_pkg::*;

    // Condition decode
    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_BZ:  o_taken = i_flag_z;
            COND_BNZ: o_taken = ~i_flag_z;
            COND_BMI: o_taken = i_flag_s;
            COND_BPL: o_taken = ~i_flag_s;
            default:  o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Initiator side of the ALU interface: accepts commands, drives the combinational ALU from
// registers, waits the settle time, captures result/flags and returns a response.
module alu_cmd_sequencer #(
    parameter int DW      = 32,
    parameter int ALU_LAT = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [4:0]    cmd_op,
    input  logic [DW-1:0] cmd_a,
    input  logic [DW-1:0] cmd_b,
    input  logic [4:0]    cmd_shamt,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic [4:0]    alu_shamt,
    output logic [3:0]    alu_func,
    input  logic [DW-1:0] alu_out,
    input  logic [2:0]    alu_flags,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic [2:0]    rsp_flags,
    output logic          rsp_taken,
    output logic          rsp_err
);
    import alu_pkg::*;

    localparam int CNT_W = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    seq_state_t    r_state;
    seq_state_t    w_next;

    logic [3:0]    r_func;
    logic [DW-1:0] r_a;
    logic [DW-1:0] r_b;
    logic [4:0]    r_shamt;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]    r_flags;

    logic [DW-1:0] r_alu_in1;
    logic [DW-1:0] r_alu_in2;
    logic [4:0]    r_alu_shamt;
    logic [3:0]    r_alu_func;

    logic          r_rsp_valid;
    logic [DW-1:0] r_rsp_data;
    logic [2:0]    r_rsp_flags;
    logic          r_rsp_taken;
    logic          r_rsp_err;

    logic          w_is_branch;
    logic          w_legal;
    logic          w_taken;

    assign w_is_branch = cmd_op[4];
    assign w_legal     = is_legal_func(cmd_op[3:0]);

    // Branches resolve against the sticky flags as they stand at acceptance.
    alu_cond_eval u_cond_eval (
        .i_flag_s (r_flags[FLG_S]),
        .i_flag_z (r_flags[FLG_Z]),
        .i_cond   (cmd_op[1:0]),
        .o_taken  (w_taken)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_is_branch || !w_legal) begin
                        w_next = ST_RESP;
                    end else begin
                        w_next = ST_ISSUE;
                    end
                end else begin
                    w_next = ST_IDLE;
                end
            end
            ST_ISSUE: w_next = ST_WAIT;
            ST_WAIT: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next = ST_RESP;
                end else begin
                    w_next = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_next = ST_IDLE;
                end else begin
                    w_next = ST_RESP;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Command latch, ALU drive, settle counter, flag capture and response registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_func      <= 4'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_shamt     <= 5'd0;
            r_cnt       <= {CNT_W{1'b0}};
            r_flags     <= 3'b000;
            r_alu_in1   <= '0;
            r_alu_in2   <= '0;
            r_alu_shamt <= 5'd0;
            r_alu_func  <= 4'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_flags <= 3'b000;
            r_rsp_taken <= 1'b0;
            r_rsp_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_func  <= cmd_op[3:0];
                        r_a     <= cmd_a;
                        r_b     <= cmd_b;
                        r_shamt <= cmd_shamt;
                        // Branches and illegal funcs answer directly without touching the ALU.
                        if (w_is_branch || !w_legal) begin
                            r_rsp_valid <= 1'b1;
                            r_rsp_data  <= '0;
                            r_rsp_flags <= r_flags;
                            r_rsp_taken <= w_is_branch & w_taken;
                            r_rsp_err   <= ~w_is_branch;
                        end
                    end
                end
                ST_ISSUE: begin
                    r_alu_in1   <= r_a;
                    r_alu_in2   <= r_b;
                    r_alu_shamt <= r_shamt;
                    r_alu_func  <= r_func;
                    r_cnt       <= CNT_W'(ALU_LAT - 1);
                end
                ST_WAIT: begin
                    if (r_cnt == {CNT_W{1'b0}}) begin
                        r_flags     <= alu_flags;
                        r_rsp_valid <= 1'b1;
                        r_rsp_data  <= alu_out;
                        r_rsp_flags <= alu_flags;
                        r_rsp_taken <= 1'b0;
                        r_rsp_err   <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign alu_in1   = r_alu_in1;
    assign alu_in2   = r_alu_in2;
    assign alu_shamt = r_alu_shamt;
    assign alu_func  = r_alu_func;
    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign rsp_flags = r_rsp_flags;
    assign rsp_taken = r_rsp_taken;
    assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer: two instances (ALU_LAT=1 and 3), each behind a
// behavioural ALU whose outputs are garbage until the settle time has elapsed.
module tb_alu_cmd_sequencer;

    localparam int LAT1 = 1;
    localparam int LAT3 = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid1, cmd_valid3, rsp_ready1, rsp_ready3;
    logic [4:0]  cmd_op;
    logic [31:0] cmd_a, cmd_b;
    logic [4:0]  cmd_shamt;

    logic        ready1, rv1, rt1, re1;
    logic [31:0] in1_1, in2_1, out_1, rd1;
    logic [4:0]  sh_1;
    logic [3:0]  func_1;
    logic [2:0]  flags_1, rf1;

    logic        ready3, rv3, rt3, re3;
    logic [31:0] in1_3, in2_3, out_3, rd3;
    logic [4:0]  sh_3;
    logic [3:0]  func_3;
    logic [2:0]  flags_3, rf3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_cmd_sequencer #(.DW(32), .ALU_LAT(LAT1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid1), .cmd_ready(ready1), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt), .alu_in1(in1_1), .alu_in2(in2_1),
        .alu_shamt(sh_1), .alu_func(func_1), .alu_out(out_1), .alu_flags(flags_1),
        .rsp_valid(rv1), .rsp_ready(rsp_ready1), .rsp_data(rd1), .rsp_flags(rf1),
        .rsp_taken(rt1), .rsp_err(re1)
    );

    alu_cmd_sequencer #(.DW(32), .ALU_LAT(LAT3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid3), .cmd_ready(ready3), .cmd_op(cmd_op),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_shamt(cmd_shamt), .alu_in1(in1_3), .alu_in2(in2_3),
        .alu_shamt(sh_3), .alu_func(func_3), .alu_out(out_3), .alu_flags(flags_3),
        .rsp_valid(rv3), .rsp_ready(rsp_ready3), .rsp_data(rd3), .rsp_flags(rf3),
        .rsp_taken(rt3), .rsp_err(re3)
    );

    // Reference ALU: returns {carry, sign, zero, result}; SUB carry is the borrow.
    function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [4:0] sh, input logic [3:0] f);
        logic [32:0] w;
        logic [31:0] r;
        logic        c;
        w = 33'd0;
        r = 32'd0;
        c = 1'b0;
        case (f)
            4'd0: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; end
            4'd1: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = ~a;
            4'd6: r = a << sh;
            4'd7: r = $unsigned($signed(a) >>> sh);
            4'd8: r = a >> sh;
            default: r = 32'd0;
        endcase
        return {c, r[31], (r == 32'd0), r};
    endfunction

    logic [72:0] snap1 = '0, snap3 = '0;
    int          age1 = 100, age3 = 100;
    logic [34:0] m1, m3;
    logic        ok1, ok3;

    // Track how many cycles each ALU's inputs have been stable
    always @(posedge clk) begin
        #1;
        if ({in1_1, in2_1, sh_1, func_1} != snap1) begin
            snap1 <= {in1_1, in2_1, sh_1, func_1};
            age1  <= 0;
        end else if (age1 < 100) begin
            age1 <= age1 + 1;
        end
        if ({in1_3, in2_3, sh_3, func_3} != snap3) begin
            snap3 <= {in1_3, in2_3, sh_3, func_3};
            age3  <= 0;
        end else if (age3 < 100) begin
            age3 <= age3 + 1;
        end
    end

    assign m1  = alu_model(in1_1, in2_1, sh_1, func_1);
    assign m3  = alu_model(in1_3, in2_3, sh_3, func_3);
    assign ok1 = ({in1_1, in2_1, sh_1, func_1} == snap1) && (age1 >= LAT1 - 1);
    assign ok3 = ({in1_3, in2_3, sh_3, func_3} == snap3) && (age3 >= LAT3 - 1);
    assign out_1   = ok1 ? m1[31:0]  : (m1[31:0] ^ 32'hDEADBEEF);
    assign flags_1 = ok1 ? m1[34:32] : ~m1[34:32];
    assign out_3   = ok3 ? m3[31:0]  : (m3[31:0] ^ 32'hDEADBEEF);
    assign flags_3 = ok3 ? m3[34:32] : ~m3[34:32];

    // Present one command to dut1; lat = negedges after the accept edge until rsp_valid (-1 on timeout)
    task automatic send1(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, output int lat);
        @(negedge clk);
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_shamt = sh; cmd_valid1 = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            cmd_valid1 = 1'b0;
            if (rv1 === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic ack1;
        rsp_ready1 = 1'b1;
        @(negedge clk);
        rsp_ready1 = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (ready1 !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready: got %b exp 1", ready1); end
        checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rv1); end
        checks++; if ({rd1, rf1, rt1, re1} !== 37'd0) begin errors++; $display("FAIL reset_rsp: got %h exp 0", {rd1, rf1, rt1, re1}); end
        checks++; if ({in1_1, in2_1, sh_1, func_1} !== 73'd0) begin errors++; $display("FAIL reset_alu_in: got %h exp 0", {in1_1, in2_1, sh_1, func_1}); end
        checks++; if (ready3 !== 1'b1 || rv3 !== 1'b0) begin errors++; $display("FAIL reset_dut3: got ready=%b valid=%b exp 1/0", ready3, rv3); end
    endtask

    task automatic test_add;
        int lat;
        send1(5'h00, 32'd5, 32'd7, 5'd0, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL add_latency: got %0d exp 3", lat); end
        checks++; if (rd1 !== 32'd12) begin errors++; $display("FAIL add_data: got %0d exp 12", rd1); end
        checks++; if (rf1 !== 3'b000 || re1 !== 1'b0 || rt1 !== 1'b0) begin errors++; $display("FAIL add_flags: got f=%b e=%b t=%b exp 000/0/0", rf1, re1, rt1); end
        ack1();
    endtask

    task automatic test_illegal;
        int lat;
        send1(5'h00, 32'd5, 32'd7, 5'd0, lat);
        ack1();
        send1(5'h0A, 32'd99, 32'd1, 5'd3, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency: got %0d exp 1", lat); end
        checks++; if (re1 !== 1'b1 || rd1 !== 32'd0) begin errors++; $display("FAIL illegal_rsp: got err=%b data=%h exp 1/0", re1, rd1); end
        checks++; if (rf1 !== 3'b000) begin errors++; $display("FAIL illegal_flags: got %b exp 000", rf1); end
        checks++; if (in1_1 !== 32'd5 || func_1 !== 4'd0) begin errors++; $display("FAIL illegal_alu_hold: got in1=%0d func=%0d exp 5/0", in1_1, func_1); end
        ack1();
    endtask

    task automatic test_sub_branch;
        int lat;
        send1(5'h01, 32'd3, 32'd3, 5'd0, lat);
        checks++; if (lat !== 3 || rd1 !== 32'd0 || rf1 !== 3'b001) begin errors++; $display("FAIL sub_eq: got lat=%0d data=%h f=%b exp 3/0/001", lat, rd1, rf1); end
        ack1();
        send1(5'h10, 32'd0, 32'd0, 5'd0, lat);
        checks++; if (lat !== 1 || rt1 !== 1'b1 || rd1 !== 32'd0 || re1 !== 1'b0) begin errors++; $display("FAIL bz_taken: got lat=%0d t=%b d=%h e=%b exp 1/1/0/0", lat, rt1, rd1, re1); end
        checks++; if (rf1 !== 3'b001) begin errors++; $display("FAIL bz_flags: got %b exp 001", rf1); end
        ack1();
        send1(5'h11, 32'd0, 32'd0, 5'd0, lat);
        checks++; if (lat !== 1 || rt1 !== 1'b0) begin errors++; $display("FAIL bnz: got lat=%0d t=%b exp 1/0", lat, rt1); end
        ack1();
        send1(5'h01, 32'd3, 32'd5, 5'd0, lat);
        checks++; if (rd1 !== 32'hFFFFFFFE || rf1 !== 3'b110) begin errors++; $display("FAIL sub_neg: got data=%h f=%b exp fffffffe/110", rd1, rf1); end
        ack1();
        send1(5'h12, 32'd0, 32'd0, 5'd0, lat);
        checks++; if (rt1 !== 1'b1 || rf1 !== 3'b110) begin errors++; $display("FAIL bmi: got t=%b f=%b exp 1/110", rt1, rf1); end
        ack1();
        send1(5'h13, 32'd0, 32'd0, 5'd0, lat);
        checks++; if (rt1 !== 1'b0) begin errors++; $display("FAIL bpl: got t=%b exp 0", rt1); end
        ack1();
    endtask

    task automatic test_stall;
        int lat;
        send1(5'h00, 32'hFFFFFFFF, 32'd1, 5'd0, lat);
        checks++; if (lat !== 3 || rd1 !== 32'd0 || rf1 !== 3'b101) begin errors++; $display("FAIL add_carry: got lat=%0d data=%h f=%b exp 3/0/101", lat, rd1, rf1); end
        cmd_op = 5'h04; cmd_a = 32'hF0F0F0F0; cmd_b = 32'h0F0F0F0F; cmd_valid1 = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if (rv1 !== 1'b1 || rd1 !== 32'd0 || rf1 !== 3'b101 || ready1 !== 1'b0) begin
                errors++; $display("FAIL stall_hold: cyc %0d got v=%b d=%h f=%b rdy=%b exp 1/0/101/0", k, rv1, rd1, rf1, ready1);
            end
        end
        rsp_ready1 = 1'b1;
        @(negedge clk);
        checks++; if (rv1 !== 1'b0 || ready1 !== 1'b1) begin errors++; $display("FAIL stall_release: got v=%b rdy=%b exp 0/1", rv1, ready1); end
        cmd_valid1 = 1'b0;
        rsp_ready1 = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (rv1 !== 1'b0 || func_1 !== 4'd0) begin errors++; $display("FAIL stall_no_accept: got v=%b func=%0d exp 0/0", rv1, func_1); end
    endtask

    task automatic test_reset_mid;
        int lat;
        @(negedge clk);
        cmd_op = 5'h01; cmd_a = 32'd3; cmd_b = 32'd5; cmd_valid1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid1 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (rv1 !== 1'b0 || ready1 !== 1'b1 || rf1 !== 3'b000) begin errors++; $display("FAIL rst_mid: got v=%b rdy=%b f=%b exp 0/1/000", rv1, ready1, rf1); end
        repeat (3) @(negedge clk);
        checks++; if (rv1 !== 1'b0) begin errors++; $display("FAIL rst_mid_no_rsp: got %b exp 0", rv1); end
        send1(5'h10, 32'd0, 32'd0, 5'd0, lat);
        checks++; if (lat !== 1 || rt1 !== 1'b0 || rf1 !== 3'b000) begin errors++; $display("FAIL rst_sticky: got lat=%0d t=%b f=%b exp 1/0/000", lat, rt1, rf1); end
        ack1();
    endtask

    task automatic test_lat3;
        int lat;
        @(negedge clk);
        cmd_op = 5'h06; cmd_a = 32'd1; cmd_b = 32'd0; cmd_shamt = 5'd4; cmd_valid3 = 1'b1;
        @(posedge clk);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            cmd_valid3 = 1'b0;
            if (rv3 === 1'b1) begin
                lat = k;
                break;
            end
        end
        checks++; if (lat !== 5) begin errors++; $display("FAIL lat3_latency: got %0d exp 5", lat); end
        checks++; if (rd3 !== 32'd16 || rf3 !== 3'b000) begin errors++; $display("FAIL lat3_data: got d=%0d f=%b exp 16/000", rd3, rf3); end
        checks++; if (re3 !== 1'b0 || rt3 !== 1'b0 || in1_3 !== 32'd1 || sh_3 !== 5'd4) begin errors++; $display("FAIL lat3_misc: got e=%b t=%b in1=%0d sh=%0d exp 0/0/1/4", re3, rt3, in1_3, sh_3); end
        rsp_ready3 = 1'b1;
        @(negedge clk);
        rsp_ready3 = 1'b0;
        checks++; if (rv3 !== 1'b0 || ready3 !== 1'b1) begin errors++; $display("FAIL lat3_ack: got v=%b rdy=%b exp 0/1", rv3, ready3); end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid1 = 1'b0; cmd_valid3 = 1'b0;
        rsp_ready1 = 1'b0; rsp_ready3 = 1'b0;
        cmd_op = 5'd0; cmd_a = 32'd0; cmd_b = 32'd0; cmd_shamt = 5'd0;
        test_reset();
        test_add();
        test_illegal();
        test_sub_branch();
        test_stall();
        test_reset_mid();
        test_lat3();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
